rc4_prga_decrypt: RTL and testbench
===================================

Name: rc4_prga_decrypt

Overview:
RC4 pseudo-random generation and decrypt stage that sits directly downstream of s_array_shuffle. Once the shuffle has finished, it reads and swaps entries in the shared 256x8 S memory to produce the keystream. It XORs each keystream byte with the matching byte of the encrypted-message ROM and writes the plaintext into the decrypted-message RAM. The top-level controller arbitrates S-memory ownership and raises start_decrypt after the shuffle's finish.

Parameters:
MSG_LEN, 32, number of message bytes processed (1..2**MSG_AW).
MSG_AW, 5, address width of the encrypted ROM and the decrypted RAM.

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
start_decrypt  in  1  level request; sampled only in IDLE
s_q  in  8  S-memory read data; valid one cycle after s_address is presented
rom_q  in  8  encrypted ROM read data; one-cycle read latency
s_address  out  8  S-memory address
s_data  out  8  S-memory write data
s_wren  out  1  S-memory write enable
rom_address  out  MSG_AW  encrypted ROM address (equals k)
msg_address  out  MSG_AW  decrypted RAM address
msg_data  out  8  decrypted RAM write data
msg_wren  out  1  decrypted RAM write enable
finish  out  1  high while in DONE

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE. i, j, k, si, sj, f are 0. All outputs are 0.
- Internal widths: i, j, si, sj, f are 8 bits and wrap modulo 256. k is MSG_AW+1 bits.
- Start: IDLE to INC_I when start_decrypt=1. At the same time i, j and k are cleared to 0.
- State sequence per byte, one cycle per state:
  - INC_I: i<=i+1.
  - RD_SI: s_address=i.
  - WAIT_SI: wait for read data.
  - LATCH_SI: si<=s_q; j<=j+s_q.
  - RD_SJ: s_address=j.
  - WAIT_SJ: wait for read data.
  - LATCH_SJ: sj<=s_q.
  - WR_SI: s_address=i, s_data=sj, s_wren=1.
  - WR_SJ: s_address=j, s_data=si, s_wren=1.
  - RD_F: s_address=si+sj (mod 256); rom_address=k.
  - WAIT_F: wait for read data.
  - LATCH_F: f<=s_q ^ rom_q.
  - WR_MSG: msg_address=k, msg_data=f, msg_wren=1.
  - NEXT: k<=k+1. Go to DONE if k+1==MSG_LEN, otherwise to INC_I.
- Throughput: 14 cycles per byte. finish rises 14*MSG_LEN+1 cycles after start_decrypt is sampled.
- Write enables: s_wren and msg_wren are high for exactly one cycle each, and only in their write states. Outputs not driven in a state are 0, except rom_address, which holds k.
- i==j: WR_SI and WR_SJ target the same address with the same value. The result is a legal no-op and needs no special casing.
- DONE: finish=1. Return to IDLE when start_decrypt=0. If start_decrypt stays high, remain in DONE; there is no auto-restart.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A partially written RAM is acceptable.

Optional Feature:
RC4_CHAR_CHECK_EN adds:
- Output key_valid (1 bit) and an ABORT state.
- In LATCH_F, if the plaintext is not in 8'h61..8'h7A and not 8'h20, the FSM goes to ABORT instead of WR_MSG. The byte is not written.
- ABORT behaves like DONE but drives finish=1 with key_valid=0.
- Normal completion gives key_valid=1 in DONE. key_valid is 0 at reset and in IDLE.
- Without the macro, there is no key_valid port and every byte is written regardless of value.

Decomposition:
- Shared package rc4_pkg holds:
  - the state enum typedef;
  - constants S_SIZE=256, CHAR_LO=8'h61, CHAR_HI=8'h7A, CHAR_SPACE=8'h20;
  - typedef byte_t (logic [7:0]).
- No sub-module. A single FSM plus datapath fits in one module.

Test Plan:
1. S memory model preset to identity (S[n]=n), rom[0]=8'h63, start=1. Required: s_wren writes S[1]=1 twice, then a read at address 2. Then msg_address=0, msg_data=8'h61, with msg_wren high for one cycle.
2. Continue case 1 with rom[1]=8'h67. Required: j=3, writes S[2]=3 and S[3]=2, read at address 5. Then msg_data=8'h62 at msg_address=1.
3. Full run, MSG_LEN=32, identity S, rom set so the software reference gives all 'a'. Required: finish rises exactly 449 cycles after start is sampled. The RAM matches the reference model, and the S-memory model matches the reference final state.
4. Hold start_decrypt high after finish. Required: stays in DONE, no further writes. Drop start: IDLE next cycle and finish=0.
5. Assert reset=0 asynchronously during WR_SJ of byte 3. Required: all outputs 0 immediately. Restart produces the same RAM contents as case 3.
6. Macro on, rom[0] chosen so the plaintext is 8'h41. Required: no msg_wren pulse, then finish=1 with key_valid=0.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream/decrypt stage.
// Build option: RC4_CHAR_CHECK_EN adds the plaintext character filter and key_valid.
package rc4_pkg;

  localparam int unsigned S_SIZE  = 256;
  localparam int unsigned STATE_W = 5;

  typedef logic [7:0]         byte_t;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE     = 5'd0;
  localparam state_t ST_INC_I    = 5'd1;
  localparam state_t ST_RD_SI    = 5'd2;
  localparam state_t ST_WAIT_SI  = 5'd3;
  localparam state_t ST_LATCH_SI = 5'd4;
  localparam state_t ST_RD_SJ    = 5'd5;
  localparam state_t ST_WAIT_SJ  = 5'd6;
  localparam state_t ST_LATCH_SJ = 5'd7;
  localparam state_t ST_WR_SI    = 5'd8;
  localparam state_t ST_WR_SJ    = 5'd9;
  localparam state_t ST_RD_F     = 5'd10;
  localparam state_t ST_WAIT_F   = 5'd11;
  localparam state_t ST_LATCH_F  = 5'd12;
  localparam state_t ST_WR_MSG   = 5'd13;
  localparam state_t ST_NEXT     = 5'd14;
  localparam state_t ST_DONE     = 5'd15;
  localparam state_t ST_ABORT    = 5'd16;

  localparam byte_t CHAR_LO    = 8'h61;
  localparam byte_t CHAR_HI    = 8'h7A;
  localparam byte_t CHAR_SPACE = 8'h20;

  // Lowercase letter or space: the only plaintext a correct key can produce.
  function automatic logic is_char_ok(input byte_t b);
    return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SPACE);
  endfunction

endpackage

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generation over the shared S memory, XOR with the encrypted ROM into the message RAM.
// Build option: RC4_CHAR_CHECK_EN enables the plaintext filter, the ABORT state and key_valid.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN = 32,
  parameter int unsigned MSG_AW  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_decrypt,
  input  logic [7:0]        s_q,
  input  logic [7:0]        rom_q,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  output logic [MSG_AW-1:0] rom_address,
  output logic [MSG_AW-1:0] msg_address,
  output logic [7:0]        msg_data,
  output logic              msg_wren,
`ifdef RC4_CHAR_CHECK_EN
  output logic              key_valid,
`endif
  output logic              finish
);

  localparam int unsigned K_W = MSG_AW + 1;

  state_t         r_state, w_state_nxt;
  byte_t          r_i, r_j, r_si, r_sj, r_f;
  byte_t          w_i_nxt, w_j_nxt, w_si_nxt, w_sj_nxt, w_f_nxt;
  logic [K_W-1:0] r_k, w_k_nxt, w_k_inc;

  byte_t             w_s_address, w_s_data, w_msg_data;
  logic              w_s_wren, w_msg_wren, w_finish, w_key_valid;
  logic [MSG_AW-1:0] w_msg_address;

  assign w_k_inc = r_k + K_W'(1);

  // Next state and datapath updates.
  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_si_nxt    = r_si;
    w_sj_nxt    = r_sj;
    w_f_nxt     = r_f;
    w_k_nxt     = r_k;
    case (r_state)
      ST_IDLE: begin
        if (start_decrypt) begin
          w_state_nxt = ST_INC_I;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_k_nxt     = '0;
        end
      end
      ST_INC_I: begin
        w_i_nxt     = r_i + 8'd1;
        w_state_nxt = ST_RD_SI;
      end
      ST_RD_SI:    w_state_nxt = ST_WAIT_SI;
      ST_WAIT_SI:  w_state_nxt = ST_LATCH_SI;
      ST_LATCH_SI: begin
        w_si_nxt    = s_q;
        w_j_nxt     = r_j + s_q;
        w_state_nxt = ST_RD_SJ;
      end
      ST_RD_SJ:    w_state_nxt = ST_WAIT_SJ;
      ST_WAIT_SJ:  w_state_nxt = ST_LATCH_SJ;
      ST_LATCH_SJ: begin
        w_sj_nxt    = s_q;
        w_state_nxt = ST_WR_SI;
      end
      ST_WR_SI:    w_state_nxt = ST_WR_SJ;
      ST_WR_SJ:    w_state_nxt = ST_RD_F;
      ST_RD_F:     w_state_nxt = ST_WAIT_F;
      ST_WAIT_F:   w_state_nxt = ST_LATCH_F;
      ST_LATCH_F: begin
        w_f_nxt     = s_q ^ rom_q;
`ifdef RC4_CHAR_CHECK_EN
        w_state_nxt = is_char_ok(w_f_nxt) ? ST_WR_MSG : ST_ABORT;
`else
        w_state_nxt = ST_WR_MSG;
`endif
      end
      ST_WR_MSG:   w_state_nxt = ST_NEXT;
      ST_NEXT: begin
        w_k_nxt     = w_k_inc;
        w_state_nxt = (w_k_inc == K_W'(MSG_LEN)) ? ST_DONE : ST_INC_I;
      end
      ST_DONE, ST_ABORT: begin
        if (!start_decrypt) w_state_nxt = ST_IDLE;
      end
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered values line up with it.
  always_comb begin
    w_s_address   = '0;
    w_s_data      = '0;
    w_s_wren      = 1'b0;
    w_msg_address = '0;
    w_msg_data    = '0;
    w_msg_wren    = 1'b0;
    w_finish      = 1'b0;
    w_key_valid   = 1'b0;
    case (w_state_nxt)
      ST_RD_SI: w_s_address = w_i_nxt;
      ST_RD_SJ: w_s_address = w_j_nxt;
      ST_WR_SI: begin
        w_s_address = w_i_nxt;
        w_s_data    = w_sj_nxt;
        w_s_wren    = 1'b1;
      end
      ST_WR_SJ: begin
        w_s_address = w_j_nxt;
        w_s_data    = w_si_nxt;
        w_s_wren    = 1'b1;
      end
      ST_RD_F:  w_s_address = w_si_nxt + w_sj_nxt;
      ST_WR_MSG: begin
        w_msg_address = w_k_nxt[MSG_AW-1:0];
        w_msg_data    = w_f_nxt;
        w_msg_wren    = 1'b1;
      end
      ST_DONE: begin
        w_finish    = 1'b1;
        w_key_valid = 1'b1;
      end
      ST_ABORT: w_finish = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_si        <= '0;
      r_sj        <= '0;
      r_f         <= '0;
      r_k         <= '0;
      s_address   <= '0;
      s_data      <= '0;
      s_wren      <= 1'b0;
      rom_address <= '0;
      msg_address <= '0;
      msg_data    <= '0;
      msg_wren    <= 1'b0;
      finish      <= 1'b0;
`ifdef RC4_CHAR_CHECK_EN
      key_valid   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_i         <= w_i_nxt;
      r_j         <= w_j_nxt;
      r_si        <= w_si_nxt;
      r_sj        <= w_sj_nxt;
      r_f         <= w_f_nxt;
      r_k         <= w_k_nxt;
      s_address   <= w_s_address;
      s_data      <= w_s_data;
      s_wren      <= w_s_wren;
      rom_address <= w_k_nxt[MSG_AW-1:0];
      msg_address <= w_msg_address;
      msg_data    <= w_msg_data;
      msg_wren    <= w_msg_wren;
      finish      <= w_finish;
`ifdef RC4_CHAR_CHECK_EN
      key_valid   <= w_key_valid;
`endif
    end
  end

`ifndef RC4_CHAR_CHECK_EN
  logic w_unused;
  assign w_unused = w_key_valid;
`endif

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Scoreboard bench for rc4_prga_decrypt against a plain-arithmetic RC4 reference.
// Build option: RC4_CHAR_CHECK_EN adds the abort-on-bad-plaintext scenario.
module tb_rc4_prga_decrypt;

  localparam int MSG_LEN = 32;
  localparam int MSG_AW  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_decrypt;
  logic [7:0]        s_q, rom_q;
  logic [7:0]        s_address, s_data, msg_data;
  logic              s_wren, msg_wren, finish;
  logic [MSG_AW-1:0] rom_address, msg_address;
`ifdef RC4_CHAR_CHECK_EN
  logic              key_valid;
`endif

  always #5 clk = ~clk;

  rc4_prga_decrypt #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
    .clk(clk), .reset(reset), .start_decrypt(start_decrypt),
    .s_q(s_q), .rom_q(rom_q),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren),
    .rom_address(rom_address), .msg_address(msg_address),
    .msg_data(msg_data), .msg_wren(msg_wren),
`ifdef RC4_CHAR_CHECK_EN
    .key_valid(key_valid),
`endif
    .finish(finish)
  );

  // Memories: address registered, then data registered, so data is ready in the LATCH state.
  logic [7:0] smem [256];
  logic [7:0] sinit[256];
  logic [7:0] rom  [MSG_LEN];
  logic [7:0] ram  [MSG_LEN];
  logic [7:0] s_ar;
  logic [MSG_AW-1:0] rom_ar;
  logic       load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      for (int n = 0; n < 256; n++) smem[n] <= sinit[n];
      for (int n = 0; n < MSG_LEN; n++) ram[n] <= 8'h00;
    end else begin
      if (s_wren) smem[s_address] <= s_data;
      if (msg_wren) ram[msg_address] <= msg_data;
    end
    s_ar   <= s_address;
    s_q    <= smem[s_ar];
    rom_ar <= rom_address;
    rom_q  <= rom[rom_ar];
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model state and expectations.
  logic [15:0] swq[$], msgq[$], rdq[$];
  logic [7:0]  ks[MSG_LEN], ram_exp[MSG_LEN], s_exp[256];
  bit          exp_abort;

  task automatic ref_model(input bit push);
    logic [7:0] rs[256];
    logic [7:0] i, j, t, a, b, pt;
    for (int n = 0; n < 256; n++) rs[n] = sinit[n];
    for (int n = 0; n < MSG_LEN; n++) ram_exp[n] = 8'h00;
    i = 8'd0; j = 8'd0; exp_abort = 1'b0;
    for (int k = 0; k < MSG_LEN; k++) begin
      i = i + 8'd1;
      j = j + rs[i];
      a = rs[i]; b = rs[j];
      rs[i] = b; rs[j] = a;
      t = a + b;
      ks[k] = rs[t];
      pt = rs[t] ^ rom[k];
      if (push) begin
        swq.push_back({i, b});
        swq.push_back({j, a});
        rdq.push_back({t, 8'(k)});
      end
`ifdef RC4_CHAR_CHECK_EN
      if (!(((pt >= 8'h61) && (pt <= 8'h7A)) || (pt == 8'h20))) begin
        exp_abort = 1'b1;
        break;
      end
`endif
      if (push) msgq.push_back({8'(k), pt});
      ram_exp[k] = pt;
    end
    for (int n = 0; n < 256; n++) s_exp[n] = rs[n];
  endtask

  // Monitor: pops expected writes/reads as the DUT presents them.
  bit track = 1'b0;
  int pos = 0;
  int n_wr = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (s_wren) begin
        n_wr++;
        if (swq.size() == 0) check("s_write_unexpected", 32'({s_address, s_data}), 32'hFFFF_FFFF);
        else check("s_write", 32'({s_address, s_data}), 32'(swq.pop_front()));
      end
      if (msg_wren) begin
        n_wr++;
        if (msgq.size() == 0) check("msg_write_unexpected", 32'({8'(msg_address), msg_data}), 32'hFFFF_FFFF);
        else check("msg_write", 32'({8'(msg_address), msg_data}), 32'(msgq.pop_front()));
      end
      if (track) begin
        pos++;
        if (pos >= 2 && ((pos - 2) % 14) == 9 && rdq.size() > 0)
          check("f_read_addr", 32'({s_address, 8'(rom_address)}), 32'(rdq.pop_front()));
      end
    end
  end

  task automatic load_mem();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic set_identity();
    for (int n = 0; n < 256; n++) sinit[n] = 8'(n);
  endtask

  // Program the ROM so that the plaintext is pt_sel (0: random letters, else that constant).
  task automatic set_rom(input logic [7:0] pt_sel);
    logic [7:0] p;
    for (int k = 0; k < MSG_LEN; k++) rom[k] = 8'h00;
    ref_model(1'b0);
    for (int k = 0; k < MSG_LEN; k++) begin
      p = (pt_sel == 8'h00) ? 8'(8'h61 + 8'($urandom_range(25, 0))) : pt_sel;
      rom[k] = ks[k] ^ p;
    end
  endtask

  task automatic flush();
    swq.delete(); msgq.delete(); rdq.delete();
  endtask

  // Start a run and wait for finish; leaves start_decrypt high.
  task automatic do_run(input string tag, input int exp_cyc, input bit chk_ram);
    int n, bad;
    flush();
    ref_model(1'b1);
    @(posedge clk); #1;
    start_decrypt = 1'b1;
    pos = 0; track = 1'b1;
    n = 0;
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (finish) break;
    end
    track = 1'b0;
    check({tag, "_finish_latency"}, 32'(n), 32'(exp_cyc));
    check({tag, "_pending"}, 32'(swq.size() + msgq.size() + rdq.size()), 32'd0);
`ifdef RC4_CHAR_CHECK_EN
    check({tag, "_key_valid"}, 32'(key_valid), 32'(!exp_abort));
`endif
    if (chk_ram) begin
      bad = 0;
      for (int k = 0; k < MSG_LEN; k++) if (ram[k] !== ram_exp[k]) bad++;
      check({tag, "_ram_mismatches"}, 32'(bad), 32'd0);
      bad = 0;
      for (int m = 0; m < 256; m++) if (smem[m] !== s_exp[m]) bad++;
      check({tag, "_smem_mismatches"}, 32'(bad), 32'd0);
    end
  endtask

  task automatic stop_run();
    start_decrypt = 1'b0;
    @(posedge clk); #1;
    check("idle_finish", 32'(finish), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_outs"}, 32'({s_address, s_data, 3'b0, msg_address, msg_data}), 32'd0);
    check({tag, "_ctl"}, 32'({s_wren, msg_wren, finish, 3'b0, rom_address}), 32'd0);
  endtask

  initial begin
    int n, w0;
    reset = 1'b0; start_decrypt = 1'b0;
    set_identity();
    for (int k = 0; k < MSG_LEN; k++) rom[k] = 8'h00;
    load_mem();
    repeat (2) @(posedge clk);
    #1 check_outputs_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("idle");

    // Identity S, first two bytes fixed, the rest random lowercase.
    set_identity();
    set_rom(8'h00);
    rom[0] = 8'h63; rom[1] = 8'h67;
    load_mem();
    do_run("runA", 14 * MSG_LEN + 1, 1'b1);
    check("byte0_plain", 32'(ram[0]), 32'h61);
    check("byte1_plain", 32'(ram[1]), 32'h62);
    check("s_after_byte1_2", 32'(smem[2]), 32'd3);
    stop_run();

    // All-'a' message, then hold start high in DONE.
    set_identity();
    set_rom(8'h61);
    load_mem();
    do_run("runB", 14 * MSG_LEN + 1, 1'b1);
    w0 = n_wr;
    n = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (finish) n++;
    end
    check("done_hold_finish", 32'(n), 32'd20);
    check("done_hold_no_writes", 32'(n_wr - w0), 32'd0);
    stop_run();
    check_outputs_zero("after_done");

    // Reset during WR_SJ of byte 3, then a clean rerun must match the all-'a' result.
    load_mem();
    flush();
    ref_model(1'b1);
    @(posedge clk); #1;
    start_decrypt = 1'b1;
    n = 0; w0 = 0;
    while (n < 200 && w0 < 6) begin
      @(posedge clk); #1;
      n++;
      if (s_wren) w0++;
    end
    check("reach_wr_sj_byte3", 32'(w0), 32'd6);
    #2 reset = 1'b0;
    #1 check_outputs_zero("async_reset");
    start_decrypt = 1'b0;
    flush();
    repeat (2) @(posedge clk);
    set_identity();
    load_mem();
    @(negedge clk) reset = 1'b1;
    do_run("runC", 14 * MSG_LEN + 1, 1'b1);
    check("runC_byte31", 32'(ram[MSG_LEN-1]), 32'h61);
    stop_run();

    // Random permutation of S with random letters.
    set_identity();
    for (int m = 255; m > 0; m--) begin
      int r; logic [7:0] tmp;
      r = $urandom_range(m, 0);
      tmp = sinit[m]; sinit[m] = sinit[r]; sinit[r] = tmp;
    end
    set_rom(8'h00);
    load_mem();
    do_run("runD", 14 * MSG_LEN + 1, 1'b1);
    stop_run();

`ifdef RC4_CHAR_CHECK_EN
    // Uppercase plaintext in byte 0 aborts before any message write.
    set_identity();
    set_rom(8'h61);
    rom[0] = 8'h43;
    load_mem();
    do_run("abort", 13, 1'b1);
    check("abort_ram0", 32'(ram[0]), 32'h00);
    stop_run();
    check("idle_key_valid", 32'(key_valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
